// File: rtl/conv_sched_ctrl_if.sv
// rtl/conv_sched_ctrl_if.sv - control/status bundle between the convolution sequencer and its datapath
// Purpose : groups the sequencer's status inputs and every control output it drives.
// Modports: master - sequencer side (receives start/status, drives controls)
//           slave  - datapath/environment side (drives start/status, receives controls)
// Signals : start, IF_done, Filter_done, filter_end, finish_filter, finish_row, write_done (to master)
//           read-controller enables, IF/filter address-generator controls, filter SP read,
//           MAC register loads/clears, conv_done, busy, done (from master)
// Option  : CONV_SCHED_PERF_CNT_EN adds cycle_cnt and mac_cnt (width CYC_WIDTH).
interface conv_sched_ctrl_if;
    logic start;
    logic IF_done;
    logic Filter_done;
    logic filter_end;
    logic finish_filter;
    logic finish_row;
    logic write_done;

    logic IF_read_cntrl_en;
    logic Filter_read_cntrl__en;
    logic ld_input_head;
    logic ld_row_ptr;
    logic row_ptr_cnt_en;
    logic clr_row_ptr;
    logic sel;
    logic ld_filter_head;
    logic clr_filter_head;
    logic index_cnt_en;
    logic clr_index;
    logic filter_ren;
    logic chip_en;
    logic ld1;
    logic ld2;
    logic ld3;
    logic clr1;
    logic clr2;
    logic clr3;
    logic conv_done;
    logic busy;
    logic done;

`ifdef CONV_SCHED_PERF_CNT_EN
    parameter int CYC_WIDTH = 32;
    logic [CYC_WIDTH-1:0] cycle_cnt;
    logic [CYC_WIDTH-1:0] mac_cnt;

    modport master (
        input  start, IF_done, Filter_done, filter_end, finish_filter, finish_row, write_done,
        output IF_read_cntrl_en, Filter_read_cntrl__en, ld_input_head, ld_row_ptr, row_ptr_cnt_en,
               clr_row_ptr, sel, ld_filter_head, clr_filter_head, index_cnt_en, clr_index,
               filter_ren, chip_en, ld1, ld2, ld3, clr1, clr2, clr3, conv_done, busy, done,
               cycle_cnt, mac_cnt
    );
    modport slave (
        output start, IF_done, Filter_done, filter_end, finish_filter, finish_row, write_done,
        input  IF_read_cntrl_en, Filter_read_cntrl__en, ld_input_head, ld_row_ptr, row_ptr_cnt_en,
               clr_row_ptr, sel, ld_filter_head, clr_filter_head, index_cnt_en, clr_index,
               filter_ren, chip_en, ld1, ld2, ld3, clr1, clr2, clr3, conv_done, busy, done,
               cycle_cnt, mac_cnt
    );
`else
    modport master (
        input  start, IF_done, Filter_done, filter_end, finish_filter, finish_row, write_done,
        output IF_read_cntrl_en, Filter_read_cntrl__en, ld_input_head, ld_row_ptr, row_ptr_cnt_en,
               clr_row_ptr, sel, ld_filter_head, clr_filter_head, index_cnt_en, clr_index,
               filter_ren, chip_en, ld1, ld2, ld3, clr1, clr2, clr3, conv_done, busy, done
    );
    modport slave (
        output start, IF_done, Filter_done, filter_end, finish_filter, finish_row, write_done,
        input  IF_read_cntrl_en, Filter_read_cntrl__en, ld_input_head, ld_row_ptr, row_ptr_cnt_en,
               clr_row_ptr, sel, ld_filter_head, clr_filter_head, index_cnt_en, clr_index,
               filter_ren, chip_en, ld1, ld2, ld3, clr1, clr2, clr3, conv_done, busy, done
    );
`endif
endinterface

// File: rtl/conv_sched_ctrl.sv
// rtl/conv_sched_ctrl.sv - top-level sequencer for the convolution datapath
// Purpose : loads both scratchpads, issues FILTER_SIZE filter reads per output through a
//           PIPE_DEPTH-stage MAC pipeline, drains it, hands the sum to the write controller
//           and walks every filter/row window until the last one is done.
// Ports   : clk, rst (asynchronous, active-high)
//           bus (conv_sched_ctrl_if.master) - status inputs and all control outputs
// Option  : CONV_SCHED_PERF_CNT_EN adds bus.cycle_cnt / bus.mac_cnt performance counters.
module conv_sched_ctrl #(
    parameter int FILTER_SIZE = 4,
    parameter int PIPE_DEPTH  = 3,
    parameter int CYC_WIDTH   = 32
) (
    input  logic              clk,
    input  logic              rst,
    conv_sched_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(FILTER_SIZE + 1);
    localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(FILTER_SIZE - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_INIT, S_ISSUE, S_DRAIN, S_EMIT, S_NEXT_F, S_NEXT_R, S_FIN
    } state_t;

    state_t                state, state_nxt;
    logic [PIPE_DEPTH-1:0] vld, vld_nxt;
    logic [CNT_W-1:0]      issue_cnt;
    logic                  if_seen, flt_seen;

    logic rd_en_q, init_q, issue_q, emit_q, next_f_q, next_r_q, busy_q, done_q;

    // The issue count alone decides when a window is complete; filter_end is
    // only a redundant hint from the index counter.
    logic unused_filter_end;
    assign unused_filter_end = bus.filter_end;

    // Bit k set means the issue made k+1 cycles ago is at MAC stage k+1.
    assign vld_nxt = {vld[PIPE_DEPTH-2:0], (state == S_ISSUE)};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_LOAD;
            S_LOAD:   if ((if_seen || bus.IF_done) && (flt_seen || bus.Filter_done))
                          state_nxt = S_INIT;
            S_INIT:   state_nxt = S_ISSUE;
            S_ISSUE:  if (issue_cnt == LAST_ISSUE) state_nxt = S_DRAIN;
            S_DRAIN:  if (vld_nxt == '0) state_nxt = S_EMIT;
            S_EMIT:   if (bus.write_done) begin
                          if (!bus.finish_filter)   state_nxt = S_NEXT_F;
                          else if (!bus.finish_row) state_nxt = S_NEXT_R;
                          else                      state_nxt = S_FIN;
                      end
            S_NEXT_F: state_nxt = S_ISSUE;
            S_NEXT_R: state_nxt = S_ISSUE;
            S_FIN:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output flags are registered from the next state so they line up with the
    // state they decode while still coming straight out of flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            vld       <= '0;
            issue_cnt <= '0;
            if_seen   <= 1'b0;
            flt_seen  <= 1'b0;
            rd_en_q   <= 1'b0;
            init_q    <= 1'b0;
            issue_q   <= 1'b0;
            emit_q    <= 1'b0;
            next_f_q  <= 1'b0;
            next_r_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            vld   <= vld_nxt;
            if (state == S_ISSUE)
                issue_cnt <= (state_nxt == S_DRAIN) ? '0 : issue_cnt + 1'b1;
            if (state == S_LOAD) begin
                if_seen  <= if_seen  | bus.IF_done;
                flt_seen <= flt_seen | bus.Filter_done;
            end else begin
                if_seen  <= 1'b0;
                flt_seen <= 1'b0;
            end
            rd_en_q  <= (state_nxt == S_LOAD);
            init_q   <= (state_nxt == S_INIT);
            issue_q  <= (state_nxt == S_ISSUE);
            emit_q   <= (state_nxt == S_EMIT);
            next_f_q <= (state_nxt == S_NEXT_F);
            next_r_q <= (state_nxt == S_NEXT_R);
            busy_q   <= (state_nxt != S_IDLE);
            done_q   <= (state_nxt == S_FIN);
        end
    end

    // The MAC clears must land in the very cycle the sum is taken, so the
    // EMIT-exit clears are the only outputs gated directly by an input.
    logic clr_pipe;
    assign clr_pipe = init_q | (emit_q & bus.write_done);

    assign bus.IF_read_cntrl_en      = rd_en_q;
    assign bus.Filter_read_cntrl__en = rd_en_q;
    assign bus.ld_input_head         = init_q | next_f_q | next_r_q;
    assign bus.ld_row_ptr            = next_r_q;
    assign bus.row_ptr_cnt_en        = next_r_q;
    assign bus.clr_row_ptr           = init_q;
    assign bus.sel                   = issue_q;
    assign bus.ld_filter_head        = next_f_q;
    assign bus.clr_filter_head       = init_q | next_r_q;
    assign bus.index_cnt_en          = issue_q;
    assign bus.clr_index             = clr_pipe;
    assign bus.filter_ren            = issue_q;
    assign bus.chip_en               = issue_q;
    assign bus.ld1                   = vld[0];
    assign bus.ld2                   = vld[1];
    assign bus.ld3                   = vld[PIPE_DEPTH-1];
    assign bus.clr1                  = clr_pipe;
    assign bus.clr2                  = clr_pipe;
    assign bus.clr3                  = clr_pipe;
    assign bus.conv_done             = emit_q;
    assign bus.busy                  = busy_q;
    assign bus.done                  = done_q;

`ifdef CONV_SCHED_PERF_CNT_EN
    logic [CYC_WIDTH-1:0] cycle_cnt_q, mac_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            mac_cnt_q   <= '0;
        end else if (state == S_IDLE && bus.start) begin
            cycle_cnt_q <= '0;
            mac_cnt_q   <= '0;
        end else begin
            if (state != S_IDLE)   cycle_cnt_q <= cycle_cnt_q + 1'b1;
            if (vld[PIPE_DEPTH-1]) mac_cnt_q   <= mac_cnt_q + 1'b1;
        end
    end

    assign bus.cycle_cnt = cycle_cnt_q;
    assign bus.mac_cnt   = mac_cnt_q;
`else
    logic [CYC_WIDTH-1:0] unused_perf_width;
    assign unused_perf_width = '0;
`endif
endmodule
